// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: runs MULT/MULTU/DIV/DIVU over a fixed busy
// window and holds the architectural HI/LO registers.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_MDUOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic [31:0]   hi, lo, hi_next, lo_next;
  logic [31:0]   pend_hi, pend_lo, pend_hi_next, pend_lo_next;

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] abs_a, abs_b, abs_b_safe, b_safe;
  logic [31:0] sq_mag, sr_mag, sq, sr, uq, ur;
  logic        div_zero;

  // Signed division works on magnitudes so 0x80000000 / -1 cannot overflow.
  assign a_sx       = {{32{E_A[31]}}, E_A};
  assign b_sx       = {{32{E_B[31]}}, E_B};
  assign prod_s     = a_sx * b_sx;
  assign prod_u     = {32'd0, E_A} * {32'd0, E_B};
  assign div_zero   = (E_B == 32'd0);
  assign b_safe     = div_zero ? 32'd1 : E_B;
  assign abs_a      = E_A[31] ? (~E_A + 32'd1) : E_A;
  assign abs_b      = E_B[31] ? (~E_B + 32'd1) : E_B;
  assign abs_b_safe = div_zero ? 32'd1 : abs_b;
  assign sq_mag     = abs_a / abs_b_safe;
  assign sr_mag     = abs_a % abs_b_safe;
  assign sq         = (E_A[31] ^ E_B[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign sr         = E_A[31] ? (~sr_mag + 32'd1) : sr_mag;
  assign uq         = E_A / b_safe;
  assign ur         = E_A % b_safe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      hi      <= hi_next;
      lo      <= lo_next;
      pend_hi <= pend_hi_next;
      pend_lo <= pend_lo_next;
    end
  end

  // Divide by zero re-latches the current HI/LO so the commit leaves them intact.
  always_comb begin
    state_next   = state;
    count_next   = count;
    hi_next      = hi;
    lo_next      = lo;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    case (state)
      IDLE: begin
        if (E_Start && (E_MDUOp >= OP_MULT) && (E_MDUOp <= OP_DIVU)) begin
          state_next = BUSY;
          case (E_MDUOp)
            OP_MULT: begin
              {pend_hi_next, pend_lo_next} = prod_s;
              count_next = MULT_N;
            end
            OP_MULTU: begin
              {pend_hi_next, pend_lo_next} = prod_u;
              count_next = MULT_N;
            end
            OP_DIV: begin
              pend_hi_next = div_zero ? hi : sr;
              pend_lo_next = div_zero ? lo : sq;
              count_next   = DIV_N;
            end
            default: begin
              pend_hi_next = div_zero ? hi : ur;
              pend_lo_next = div_zero ? lo : uq;
              count_next   = DIV_N;
            end
          endcase
        end else if (E_MDUOp == OP_MTHI) begin
          hi_next = E_A;
        end else if (E_MDUOp == OP_MTLO) begin
          lo_next = E_A;
        end
      end
      BUSY: begin
        if (count <= ONE) begin
          hi_next    = pend_hi;
          lo_next    = pend_lo;
          count_next = '0;
          state_next = IDLE;
        end else begin
          count_next = count - ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign E_Busy = (state == BUSY);

  always_comb begin
    E_MDUOut = 32'd0;
    if (E_MDUOp == OP_MFHI)
      E_MDUOut = hi;
    else if (E_MDUOp == OP_MFLO)
      E_MDUOut = lo;
  end

endmodule
